ram_fill_arbiter: RTL and testbench

// - Parametrised successor of the two-cache RAM controller: arbitrates NUM_REQ cache-miss requesters

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_fill_arbiter_if.sv | 37 +++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/ram_fill_arbiter.sv | 97 +++++++++
 tb/tb_ram_fill_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the line-fill arbiter: FSM state codes, arbitration modes
// and the counter/offset width helpers derived from the line size.
package ram_ctrl_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // One extra bit so the counters can reach WORDS_PER_LINE without wrapping.
  function automatic int cnt_w(input int words_per_line);
    return $clog2(words_per_line) + 1;
  endfunction

  function automatic int ofs_w(input int words_per_line);
    return $clog2(words_per_line) + 1;
  endfunction

endpackage

// File: rtl/ram_fill_arbiter_if.sv
// Cache-side and memory-side signals of the line-fill arbiter; slave = arbiter,
// master = the surrounding caches plus memory.
interface ram_fill_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic                      wr_req;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_ack;
  logic [NUM_REQ-1:0]        miss_req;
  logic [NUM_REQ*ADDR_W-1:0] miss_addr;
  logic [NUM_REQ-1:0]        fill_busy;
  logic [NUM_REQ-1:0]        fill_data_we;
  logic [NUM_REQ-1:0]        fill_tag_we;
  logic [ADDR_W-1:0]         fill_addr;
  logic [DATA_W-1:0]         fill_data;
  logic                      mem_en;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_valid;

  modport slave (
    input  wr_req, wr_addr, wr_data, miss_req, miss_addr, mem_rdata, mem_valid,
    output wr_ack, fill_busy, fill_data_we, fill_tag_we, fill_addr, fill_data,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, miss_req, miss_addr, mem_rdata, mem_valid,
    input  wr_ack, fill_busy, fill_data_we, fill_tag_we, fill_addr, fill_data,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant from a request vector, fixed priority or round-robin; combinational
// grant, pointer moves to the slot after the winner only when advance is strobed.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  int               start;
  int               idx;

  // Search starts at the pointer in round-robin mode, at index 0 otherwise.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    start    = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ARB_MODE == ARB_RR && advance && found) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/ram_fill_arbiter.sv
// Arbitrates cache line-fill misses plus a single-word write port onto one pipelined memory.
// Writes ack same cycle in IDLE; fills are non-preemptive and stall writes until the line returns.
module ram_fill_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int ARB_MODE       = ARB_FIXED
) (
  input logic               clk,
  input logic               rst,
  ram_fill_arbiter_if.slave bus
);

  localparam int CNT_W  = cnt_w(WORDS_PER_LINE);
  localparam int OFS_W  = ofs_w(WORDS_PER_LINE);
  localparam int BASE_W = ADDR_W - OFS_W;

  logic [0:0]         state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [BASE_W-1:0]  base;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [BASE_W-1:0]  sel_base;

  logic in_idle;
  logic in_fill;
  logic grant_now;
  logic issuing;
  logic returning;
  logic last_ret;

  assign in_idle   = (state == ST_IDLE);
  assign in_fill   = (state == ST_FILL);
  assign grant_now = in_idle && !bus.wr_req && (|bus.miss_req);
  assign issuing   = in_fill && (issue_cnt < CNT_W'(WORDS_PER_LINE));
  assign returning = in_fill && bus.mem_valid;
  assign last_ret  = returning && (ret_cnt == CNT_W'(WORDS_PER_LINE - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.miss_req),
    .advance(grant_now),
    .grant  (arb_grant)
  );

  always_comb begin
    sel_base = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_base = bus.miss_addr[i*ADDR_W + OFS_W +: BASE_W];
    end
  end

  // Issue and return run independently; only the final return closes the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base      <= '0;
      grant_q   <= '0;
    end else if (in_idle) begin
      if (grant_now) begin
        state   <= ST_FILL;
        base    <= sel_base;
        grant_q <= arb_grant;
      end
    end else begin
      if (issuing)   issue_cnt <= issue_cnt + CNT_W'(1);
      if (returning) ret_cnt   <= ret_cnt + CNT_W'(1);
      if (last_ret) begin
        state     <= ST_IDLE;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end
    end
  end

  assign bus.wr_ack       = in_idle && bus.wr_req;
  assign bus.mem_en       = bus.wr_ack || issuing;
  assign bus.mem_wr       = bus.wr_ack;
  assign bus.mem_addr     = issuing ? {base, issue_cnt[CNT_W-2:0], 1'b0} : bus.wr_addr;
  assign bus.mem_wdata    = bus.wr_data;
  assign bus.fill_busy    = in_fill ? grant_q : '0;
  assign bus.fill_data_we = returning ? grant_q : '0;
  assign bus.fill_tag_we  = last_ret ? grant_q : '0;
  assign bus.fill_addr    = returning ? {base, ret_cnt[CNT_W-2:0], 1'b0} : bus.wr_addr;
  assign bus.fill_data    = bus.mem_rdata;

endmodule

// File: tb/tb_ram_fill_arbiter.sv
// Bench for ram_fill_arbiter: a fixed-priority 2-requester/8-word instance and a
// round-robin 4-requester/4-word instance, each behind a latency-4 memory model.
module tb_ram_fill_arbiter;

  localparam int LAT = 4;
  localparam int WA  = 8;
  localparam int WB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ptr_b = 0;

  logic [15:0] mem_store [int];
  logic [15:0] ref_store [int];
  bit          pa_v [16];
  logic [15:0] pa_addr [16];
  bit          pb_v [16];
  logic [15:0] pb_addr [16];

  ram_fill_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16)) bus_a ();
  ram_fill_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16)) bus_b ();

  ram_fill_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(WA), .ARB_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ram_fill_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(WB), .ARB_MODE(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_store.exists(int'(a))) return mem_store[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] exp_val(input logic [15:0] a);
    if (ref_store.exists(int'(a))) return ref_store[int'(a)];
    return init_val(a);
  endfunction

  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Memory model: capture requests mid-cycle, answer LAT cycles later.
  always @(negedge clk) begin
    pa_v[cyc % 16]    = bus_a.mem_en && !bus_a.mem_wr;
    pa_addr[cyc % 16] = bus_a.mem_addr;
    if (bus_a.mem_en && bus_a.mem_wr) mem_store[int'(bus_a.mem_addr)] = bus_a.mem_wdata;
    pb_v[cyc % 16]    = bus_b.mem_en && !bus_b.mem_wr;
    pb_addr[cyc % 16] = bus_b.mem_addr;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    bus_a.mem_valid = pa_v[(cyc + 16 - LAT) % 16];
    bus_a.mem_rdata = bus_a.mem_valid ? mem_read(pa_addr[(cyc + 16 - LAT) % 16]) : 16'h0;
    bus_b.mem_valid = pb_v[(cyc + 16 - LAT) % 16];
    bus_b.mem_rdata = bus_b.mem_valid ? init_val(pb_addr[(cyc + 16 - LAT) % 16]) : 16'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus_a.wr_req = 1'b0; bus_a.miss_req = '0;
    bus_b.wr_req = 1'b0; bus_b.miss_req = '0;
    step();
    rst = 1'b0;
    ptr_b = 0;
  endtask

  // Caller has driven the grant-cycle inputs; checks cycles 0..LAT+WA of one fill.
  task automatic fill_a(input int idx, input logic [15:0] addr, input bit drop, input bit wr_during);
    logic [15:0] base;
    logic [15:0] ea;
    logic [1:0]  oh;
    logic [8:0]  ectl;
    int          ret;
    oh   = 2'b01 << idx;
    base = addr - (addr % 16'(2 * WA));
    @(negedge clk);
    checks++;
    if ({bus_a.fill_busy, bus_a.fill_data_we, bus_a.mem_en} !== 5'b0) begin
      failures++;
      $display("FAIL fill_a_grant_cycle got busy=%b we=%b en=%b want 0", bus_a.fill_busy, bus_a.fill_data_we, bus_a.mem_en);
    end
    for (int k = 1; k <= LAT + WA; k++) begin
      step();
      if (k == 1 && drop) bus_a.miss_req = '0;
      if (k == 1 && wr_during) begin
        bus_a.wr_req  = 1'b1;
        bus_a.wr_addr = 16'($urandom) & 16'hFFFE;
        bus_a.wr_data = 16'($urandom);
      end
      @(negedge clk);
      ret  = k - LAT;
      ectl = {oh, (ret >= 1) ? oh : 2'b00, (ret == WA) ? oh : 2'b00, (k <= WA), 1'b0, 1'b0};
      checks++;
      if ({bus_a.fill_busy, bus_a.fill_data_we, bus_a.fill_tag_we, bus_a.mem_en, bus_a.mem_wr, bus_a.wr_ack} !== ectl) begin
        failures++;
        $display("FAIL ctl_a k=%0d got %b want %b", k,
                 {bus_a.fill_busy, bus_a.fill_data_we, bus_a.fill_tag_we, bus_a.mem_en, bus_a.mem_wr, bus_a.wr_ack}, ectl);
      end
      ea = (k <= WA) ? base + 16'(2 * (k - 1)) : bus_a.wr_addr;
      checks++;
      if (bus_a.mem_addr !== ea) begin
        failures++;
        $display("FAIL mem_addr_a k=%0d got %h want %h", k, bus_a.mem_addr, ea);
      end
      if (ret >= 1) begin
        ea = base + 16'(2 * (ret - 1));
        checks++;
        if (bus_a.fill_addr !== ea) begin
          failures++;
          $display("FAIL fill_addr_a k=%0d got %h want %h", k, bus_a.fill_addr, ea);
        end
        checks++;
        if (bus_a.fill_data !== exp_val(ea)) begin
          failures++;
          $display("FAIL fill_data_a k=%0d got %h want %h", k, bus_a.fill_data, exp_val(ea));
        end
      end
    end
  endtask

  task automatic fill_b(input int idx, input logic [15:0] addr, input bit drop);
    logic [15:0] base;
    logic [15:0] ea;
    logic [3:0]  oh;
    logic [14:0] ectl;
    int          ret;
    oh   = 4'b0001 << idx;
    base = addr - (addr % 16'(2 * WB));
    @(negedge clk);
    for (int k = 1; k <= LAT + WB; k++) begin
      step();
      if (k == 1 && drop) bus_b.miss_req = '0;
      @(negedge clk);
      ret  = k - LAT;
      ectl = {oh, (ret >= 1) ? oh : 4'b0000, (ret == WB) ? oh : 4'b0000, (k <= WB), 1'b0, 1'b0};
      checks++;
      if ({bus_b.fill_busy, bus_b.fill_data_we, bus_b.fill_tag_we, bus_b.mem_en, bus_b.mem_wr, bus_b.wr_ack} !== ectl) begin
        failures++;
        $display("FAIL ctl_b k=%0d got %b want %b", k,
                 {bus_b.fill_busy, bus_b.fill_data_we, bus_b.fill_tag_we, bus_b.mem_en, bus_b.mem_wr, bus_b.wr_ack}, ectl);
      end
      ea = (k <= WB) ? base + 16'(2 * (k - 1)) : bus_b.wr_addr;
      checks++;
      if (bus_b.mem_addr !== ea) begin
        failures++;
        $display("FAIL mem_addr_b k=%0d got %h want %h", k, bus_b.mem_addr, ea);
      end
      if (ret >= 1) begin
        ea = base + 16'(2 * (ret - 1));
        checks++;
        if (bus_b.fill_addr !== ea || bus_b.fill_data !== init_val(ea)) begin
          failures++;
          $display("FAIL fill_word_b k=%0d got %h/%h want %h/%h", k, bus_b.fill_addr, bus_b.fill_data, ea, init_val(ea));
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus_a.wr_addr = 16'($urandom);
    bus_a.wr_data = 16'($urandom);
    bus_b.wr_addr = 16'($urandom);
    @(negedge clk);
    checks++;
    if ({bus_a.fill_busy, bus_a.fill_data_we, bus_a.fill_tag_we, bus_a.mem_en, bus_a.mem_wr, bus_a.wr_ack} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctl_a got %b want 0", {bus_a.fill_busy, bus_a.fill_data_we, bus_a.fill_tag_we, bus_a.mem_en, bus_a.mem_wr, bus_a.wr_ack});
    end
    checks++;
    if (bus_a.mem_addr !== bus_a.wr_addr || bus_a.fill_addr !== bus_a.wr_addr) begin
      failures++;
      $display("FAIL reset_addr_a got %h/%h want %h", bus_a.mem_addr, bus_a.fill_addr, bus_a.wr_addr);
    end
    checks++;
    if (bus_a.mem_wdata !== bus_a.wr_data) begin
      failures++;
      $display("FAIL reset_wdata_a got %h want %h", bus_a.mem_wdata, bus_a.wr_data);
    end
    checks++;
    if ({bus_b.fill_busy, bus_b.fill_data_we, bus_b.fill_tag_we, bus_b.mem_en, bus_b.wr_ack} !== 14'b0 || bus_b.mem_addr !== bus_b.wr_addr) begin
      failures++;
      $display("FAIL reset_b got busy=%b en=%b addr=%h want 0/0/%h", bus_b.fill_busy, bus_b.mem_en, bus_b.mem_addr, bus_b.wr_addr);
    end
  endtask

  task automatic test_single_miss();
    step();
    bus_a.miss_req  = 2'b01;
    bus_a.miss_addr = {16'($urandom), 16'h1234};
    fill_a(0, 16'h1234, 1'b1, 1'b0);
    step();
    @(negedge clk);
    checks++;
    if ({bus_a.fill_busy, bus_a.fill_data_we, bus_a.mem_en} !== 5'b0) begin
      failures++;
      $display("FAIL single_busy_drop got busy=%b we=%b en=%b want 0", bus_a.fill_busy, bus_a.fill_data_we, bus_a.mem_en);
    end
  endtask

  task automatic test_fixed_priority();
    logic [15:0] a0, a1;
    a0 = 16'($urandom);
    a1 = 16'($urandom);
    step();
    bus_a.miss_req  = 2'b11;
    bus_a.miss_addr = {a1, a0};
    fill_a(0, a0, 1'b0, 1'b0);
    step();
    fill_a(0, a0, 1'b0, 1'b0);
    step();
    bus_a.miss_req = 2'b10;
    fill_a(1, a1, 1'b1, 1'b0);
  endtask

  task automatic test_write_vs_miss();
    logic [15:0] waddr, maddr;
    waddr = 16'($urandom) & 16'hFFFE;
    maddr = 16'($urandom);
    step();
    bus_a.wr_req    = 1'b1;
    bus_a.wr_addr   = waddr;
    bus_a.wr_data   = 16'($urandom);
    bus_a.miss_req  = 2'b01;
    bus_a.miss_addr = {16'h0, maddr};
    @(negedge clk);
    checks++;
    if ({bus_a.wr_ack, bus_a.mem_wr, bus_a.mem_en, bus_a.fill_busy} !== 5'b11100 || bus_a.mem_addr !== waddr) begin
      failures++;
      $display("FAIL wr_vs_miss_write got ack=%b wr=%b busy=%b addr=%h want 1/1/00/%h",
               bus_a.wr_ack, bus_a.mem_wr, bus_a.fill_busy, bus_a.mem_addr, waddr);
    end
    ref_store[int'(waddr)] = bus_a.wr_data;
    step();
    bus_a.wr_req = 1'b0;
    fill_a(0, maddr, 1'b1, 1'b1);
    step();
    @(negedge clk);
    checks++;
    if ({bus_a.wr_ack, bus_a.mem_wr, bus_a.mem_en} !== 3'b111 || bus_a.mem_addr !== bus_a.wr_addr) begin
      failures++;
      $display("FAIL stalled_write_accept got ack=%b wr=%b addr=%h want 1/1/%h", bus_a.wr_ack, bus_a.mem_wr, bus_a.mem_addr, bus_a.wr_addr);
    end
    ref_store[int'(bus_a.wr_addr)] = bus_a.wr_data;
    step();
    bus_a.wr_req    = 1'b0;
    bus_a.miss_req  = 2'b01;
    bus_a.miss_addr = {16'h0, waddr};
    fill_a(0, waddr, 1'b1, 1'b0);
  endtask

  task automatic test_random_a();
    logic [1:0]  r;
    logic [15:0] ad [2];
    bit          w;
    int          idx;
    for (int n = 0; n < 8; n++) begin
      step();
      bus_a.wr_req = 1'b0;
      r     = 2'($urandom_range(1, 3));
      ad[0] = 16'($urandom);
      ad[1] = 16'($urandom);
      w     = 1'($urandom_range(0, 1));
      bus_a.miss_req  = r;
      bus_a.miss_addr = {ad[1], ad[0]};
      idx = r[0] ? 0 : 1;
      fill_a(idx, ad[idx], 1'b1, w);
      if (w) begin
        step();
        @(negedge clk);
        checks++;
        if ({bus_a.wr_ack, bus_a.mem_wr} !== 2'b11 || bus_a.mem_addr !== bus_a.wr_addr) begin
          failures++;
          $display("FAIL random_write_accept n=%0d got ack=%b addr=%h want 1/%h", n, bus_a.wr_ack, bus_a.mem_addr, bus_a.wr_addr);
        end
        ref_store[int'(bus_a.wr_addr)] = bus_a.wr_data;
      end
    end
    step();
    bus_a.wr_req = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    step();
    bus_a.miss_req  = 2'b01;
    bus_a.miss_addr = {16'h0, 16'($urandom)};
    for (int k = 1; k <= LAT + 3; k++) begin
      step();
      if (k == 1) bus_a.miss_req = '0;
      if (k == LAT + 3) rst = 1'b1;
    end
    step();
    rst = 1'b0;
    ptr_b = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.fill_busy, bus_a.fill_data_we, bus_a.fill_tag_we, bus_a.mem_en} !== 7'b0 || bus_a.fill_addr !== bus_a.wr_addr) begin
        failures++;
        $display("FAIL post_reset_idle k=%0d got busy=%b we=%b en=%b faddr=%h want 0/0/0/%h",
                 k, bus_a.fill_busy, bus_a.fill_data_we, bus_a.mem_en, bus_a.fill_addr, bus_a.wr_addr);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] ad [4];
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) ad[i] = 16'($urandom);
    step();
    bus_b.wr_addr   = 16'($urandom);
    bus_b.miss_req  = 4'b1111;
    bus_b.miss_addr = {ad[3], ad[2], ad[1], ad[0]};
    for (int n = 0; n < 5; n++) begin
      if (n > 0) step();
      fill_b(order[n], ad[order[n]], n == 4);
      ptr_b = (order[n] + 1) % 4;
    end
    step();
    @(negedge clk);
    checks++;
    if (bus_b.fill_busy !== 4'b0) begin
      failures++;
      $display("FAIL rr_end_idle got busy=%b want 0000", bus_b.fill_busy);
    end
  endtask

  task automatic test_random_b();
    logic [3:0]  r;
    logic [15:0] ad [4];
    int          idx;
    for (int n = 0; n < 8; n++) begin
      step();
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) ad[i] = 16'($urandom);
      bus_b.miss_req  = r;
      bus_b.miss_addr = {ad[3], ad[2], ad[1], ad[0]};
      idx = rr_pick(r, ptr_b);
      fill_b(idx, ad[idx], 1'b1);
      ptr_b = (idx + 1) % 4;
    end
  endtask

  initial begin
    bus_a.wr_req = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.miss_req = '0; bus_a.miss_addr = '0;
    bus_a.mem_valid = 1'b0; bus_a.mem_rdata = '0;
    bus_b.wr_req = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.miss_req = '0; bus_b.miss_addr = '0;
    bus_b.mem_valid = 1'b0; bus_b.mem_rdata = '0;
    test_reset();
    test_single_miss();
    test_fixed_priority();
    test_write_vs_miss();
    test_random_a();
    test_reset_mid_fill();
    test_round_robin();
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
